// File: rtl/ras_ckpt_stack_pkg.sv
// ras_types: shared types and widths for the speculative return address stack.
//   RAS_DEPTH / RAS_XLEN : defaults that must match ras_ckpt_stack's DEPTH / XLEN.
//   RAS_PTR_W            : width of the top-of-stack pointer.
//   RAS_CNT_W            : width of the occupancy count (0..DEPTH).
//   ras_ckpt_t           : per-instruction snapshot {tos, count}, plus top_val
//                          when RAS_REPAIR_TOP_EN is defined.
package ras_types;

    localparam int RAS_DEPTH = 8;
    localparam int RAS_XLEN  = 32;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    typedef struct packed {
`ifdef RAS_REPAIR_TOP_EN
        logic [RAS_XLEN-1:0]  top_val;
`endif
        logic [RAS_PTR_W-1:0] tos;
        logic [RAS_CNT_W-1:0] count;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_stack_storage.sv
// ras_storage: DEPTH x XLEN entry array, one synchronous write port and one
// asynchronous read port. Entries have no reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module ras_storage #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ras_ckpt_stack.sv
// ras_ckpt_stack: speculative return address stack with checkpoint repair.
// Decode pushes links for calls and pops targets for returns; each decoded
// instruction receives a snapshot (dec_ckpt) which is handed back on an
// execute flush to rewind the stack, then the flushing instr's own effect
// is replayed.
// Optional feature macro: RAS_REPAIR_TOP_EN (checkpoint also restores the top entry).
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   advance                     : pipeline advance, gates all updates
//   dec_call/dec_ret/dec_link   : decode-stage instruction class and pc+4
//   pred_valid/pred_target      : return prediction (combinational)
//   dec_ckpt                    : snapshot before decode instr's effect
//   exe_flush/exe_ckpt          : execute redirect and its checkpoint
//   exe_call/exe_ret/exe_link   : class and pc+4 of the flushing instr
//   exe_ret_pred/exe_ret_actual : predicted vs computed return target
//   correct_return              : equality of the two (combinational)
module ras_ckpt_stack
    import ras_types::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int XLEN  = RAS_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            dec_call,
    input  logic            dec_ret,
    input  logic [XLEN-1:0] dec_link,
    output logic            pred_valid,
    output logic [XLEN-1:0] pred_target,
    output ras_ckpt_t       dec_ckpt,
    input  logic            exe_flush,
    input  ras_ckpt_t       exe_ckpt,
    input  logic            exe_call,
    input  logic            exe_ret,
    input  logic [XLEN-1:0] exe_link,
    input  logic [XLEN-1:0] exe_ret_pred,
    input  logic [XLEN-1:0] exe_ret_actual,
    output logic            correct_return
);

    localparam logic [RAS_CNT_W-1:0] CNT_FULL = RAS_CNT_W'(DEPTH);

    logic [RAS_PTR_W-1:0] tos, nxt_tos, base_tos, waddr;
    logic [RAS_CNT_W-1:0] count, nxt_cnt, base_cnt;
    logic [XLEN-1:0]      top_rd, op_link, wdata;
    logic                 op_call, op_ret, we, do_flush;

    ras_storage #(.DEPTH(DEPTH), .XLEN(XLEN)) u_storage (
        .clk   (clk),
        .we    (we & advance & ~rst),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (tos),
        .rdata (top_rd)
    );

    always_comb begin
        pred_target    = (count != '0) ? top_rd : '0;
        pred_valid     = dec_ret && (count != '0);
        dec_ckpt       = '0;
        dec_ckpt.tos   = tos;
        dec_ckpt.count = count;
`ifdef RAS_REPAIR_TOP_EN
        dec_ckpt.top_val = pred_target;
`endif
        correct_return = (exe_ret_pred == exe_ret_actual);
    end

    // One shared update path: the flush replays the exe instr on top of its
    // checkpoint, otherwise the decode instr acts on the live state.
    always_comb begin
        do_flush = exe_flush;
        base_tos = do_flush ? exe_ckpt.tos   : tos;
        base_cnt = do_flush ? exe_ckpt.count : count;
        op_call  = do_flush ? exe_call : dec_call;
        op_ret   = do_flush ? exe_ret  : dec_ret;
        op_link  = do_flush ? exe_link : dec_link;

        nxt_tos = base_tos;
        nxt_cnt = base_cnt;
        we      = 1'b0;
        waddr   = base_tos;
        wdata   = op_link;

        if (op_call && op_ret && (base_cnt != '0)) begin
            // coroutine swap: pop then push lands on the same slot
            we = 1'b1;
        end else if (op_call) begin
            nxt_tos = base_tos + 1'b1;
            waddr   = base_tos + 1'b1;
            we      = 1'b1;
            if (base_cnt != CNT_FULL) begin
                nxt_cnt = base_cnt + 1'b1;
            end
        end else if (op_ret && (base_cnt != '0)) begin
            nxt_tos = base_tos - 1'b1;
            nxt_cnt = base_cnt - 1'b1;
        end

`ifdef RAS_REPAIR_TOP_EN
        // Single write port: a replayed exe call owns it, so the top repair is
        // only performed when the flushing instr writes nothing itself.
        if (do_flush && !we && (exe_ckpt.count != '0)) begin
            we    = 1'b1;
            waddr = exe_ckpt.tos;
            wdata = exe_ckpt.top_val;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos   <= '0;
            count <= '0;
        end else if (advance) begin
            tos   <= nxt_tos;
            count <= nxt_cnt;
        end
    end

endmodule

// File: tb/tb_ras_ckpt_stack.sv
module tb_ras_ckpt_stack;
    import ras_types::*;

    logic        clk = 1'b0;
    logic        rst, advance, dec_call, dec_ret, exe_flush, exe_call, exe_ret;
    logic [31:0] dec_link, exe_link, exe_ret_pred, exe_ret_actual, pred_target;
    logic        pred_valid, correct_return;
    ras_ckpt_t   dec_ckpt, exe_ckpt;

    always #5 clk = ~clk;

    ras_ckpt_stack #(.DEPTH(8), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .advance(advance),
        .dec_call(dec_call), .dec_ret(dec_ret), .dec_link(dec_link),
        .pred_valid(pred_valid), .pred_target(pred_target), .dec_ckpt(dec_ckpt),
        .exe_flush(exe_flush), .exe_ckpt(exe_ckpt),
        .exe_call(exe_call), .exe_ret(exe_ret), .exe_link(exe_link),
        .exe_ret_pred(exe_ret_pred), .exe_ret_actual(exe_ret_actual),
        .correct_return(correct_return)
    );

    typedef struct {
        logic        pv;
        logic [31:0] pt;
        ras_ckpt_t   ck;
        logic        cr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          m_tos, m_cnt;
    logic [31:0] m_ent [8];
    ras_ckpt_t   ck0, saved, last_ck, obs_ck;
    logic [31:0] obs_pt;
    logic        obs_pv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic ras_ckpt_t model_ckpt();
        ras_ckpt_t c;
        c       = '0;
        c.tos   = m_tos[RAS_PTR_W-1:0];
        c.count = m_cnt[RAS_CNT_W-1:0];
`ifdef RAS_REPAIR_TOP_EN
        c.top_val = (m_cnt > 0) ? m_ent[m_tos] : 32'h0;
`endif
        return c;
    endfunction

    task automatic model_apply(input bit call, input bit ret, input logic [31:0] link);
        if (call && ret && m_cnt > 0) begin
            m_ent[m_tos] = link;
        end else if (call) begin
            m_tos = (m_tos + 1) % 8;
            m_ent[m_tos] = link;
            if (m_cnt < 8) m_cnt++;
        end else if (ret && m_cnt > 0) begin
            m_tos = (m_tos + 7) % 8;
            m_cnt--;
        end
    endtask

    task automatic cyc(input bit r, input bit adv, input bit dcall, input bit dret,
                       input logic [31:0] dlink, input bit fl, input ras_ckpt_t ck,
                       input bit ecall, input bit eret, input logic [31:0] elink);
        exp_t e, o;
        @(negedge clk);
        rst = r; advance = adv; dec_call = dcall; dec_ret = dret; dec_link = dlink;
        exe_flush = fl; exe_ckpt = ck; exe_call = ecall; exe_ret = eret; exe_link = elink;
        exe_ret_pred   = $urandom;
        exe_ret_actual = ($urandom_range(0, 1) == 1) ? exe_ret_pred : $urandom;
        e.pv = dret && (m_cnt > 0);
        e.pt = (m_cnt > 0) ? m_ent[m_tos] : 32'h0;
        e.ck = model_ckpt();
        e.cr = (exe_ret_pred == exe_ret_actual);
        exp_q.push_back(e);
        last_ck = e.ck;
        #1;
        o = exp_q.pop_front();
        chk("pred_valid", 64'(pred_valid), 64'(o.pv));
        chk("pred_target", 64'(pred_target), 64'(o.pt));
        chk("dec_ckpt", 64'(dec_ckpt), 64'(o.ck));
        chk("correct_return", 64'(correct_return), 64'(o.cr));
        obs_pt = pred_target; obs_pv = pred_valid; obs_ck = dec_ckpt;
        @(posedge clk);
        if (r) begin
            m_tos = 0; m_cnt = 0;
        end else if (adv) begin
            if (fl) begin
                m_tos = int'(ck.tos);
                m_cnt = int'(ck.count);
`ifdef RAS_REPAIR_TOP_EN
                if (!ecall && ck.count != 0) m_ent[int'(ck.tos)] = ck.top_val;
`endif
                model_apply(ecall, eret, elink);
            end else begin
                model_apply(dcall, dret, dlink);
            end
        end
    endtask

    task automatic dec(input bit call, input bit ret, input logic [31:0] link);
        cyc(0, 1, call, ret, link, 0, ck0, 0, 0, 32'h0);
    endtask

    task automatic flush(input ras_ckpt_t ck, input bit ecall, input bit eret, input logic [31:0] elink);
        cyc(0, 1, 1, 0, 32'hDEAD_0000, 1, ck, ecall, eret, elink);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ck0 = '0;
        for (int i = 0; i < 8; i++) m_ent[i] = 32'h0;
        m_tos = 0; m_cnt = 0;
        rst = 1; advance = 0; dec_call = 0; dec_ret = 0; dec_link = 0;
        exe_flush = 0; exe_ckpt = '0; exe_call = 0; exe_ret = 0; exe_link = 0;
        exe_ret_pred = 0; exe_ret_actual = 0;
        repeat (2) @(posedge clk);

        // reset state, with a return in decode
        cyc(0, 1, 0, 1, 32'h0, 0, ck0, 0, 0, 32'h0);
        chk("rst_pv", 64'(obs_pv), 64'd0);
        chk("rst_ckpt", 64'(obs_ck), 64'd0);

        // basic push/pop
        dec(1, 0, 32'h100); dec(1, 0, 32'h200); dec(1, 0, 32'h300);
        dec(0, 1, 32'h0);
        chk("ret_top", 64'(obs_pt), 64'h300);
        dec(0, 1, 32'h0); dec(0, 1, 32'h0);
        dec(0, 1, 32'h0);
        chk("empty_cnt", 64'(obs_ck.count), 64'd0);
        chk("empty_pv", 64'(obs_pv), 64'd0);
        dec(0, 0, 32'h0);
        chk("empty_tos_hold", 64'(obs_ck.tos), 64'd0);

        // wrap: 9 pushes into 8 entries
        for (int k = 1; k <= 9; k++) dec(1, 0, 32'(k * 16));
        dec(0, 0, 32'h0);
        chk("full_cnt", 64'(obs_ck.count), 64'd8);
        for (int k = 9; k >= 2; k--) begin
            dec(0, 1, 32'h0);
            chk("wrap_pop", 64'(obs_pt), 64'(k * 16));
        end
        dec(0, 1, 32'h0);
        chk("wrap_pop_invalid", 64'(obs_pv), 64'd0);

        // checkpoint rewind
        dec(1, 0, 32'hA0);
        dec(1, 0, 32'hB0);
        saved = last_ck;
        dec(0, 1, 32'h0); dec(0, 1, 32'h0);
        flush(saved, 0, 0, 32'h0);
        dec(0, 0, 32'h0);
        chk("rewind_top", 64'(obs_pt), 64'hA0);
        chk("rewind_cnt", 64'(obs_ck.count), 64'd1);

        // coroutine swap
        dec(1, 0, 32'h500);
        dec(1, 1, 32'h604);
        dec(0, 0, 32'h0);
        chk("swap_top", 64'(obs_pt), 64'h604);
        chk("swap_cnt", 64'(obs_ck.count), 64'd2);

        // wrong-path swap then flush
        dec(1, 0, 32'h700);
        dec(1, 1, 32'h800);
        saved = last_ck;
        flush(saved, 0, 0, 32'h0);
        dec(0, 0, 32'h0);
`ifdef RAS_REPAIR_TOP_EN
        chk("repair_top", 64'(obs_pt), 64'h700);
`else
        chk("repair_top", 64'(obs_pt), 64'h800);
`endif
        flush(saved, 1, 0, 32'h900);
        dec(0, 0, 32'h0);
        chk("flush_call_top", 64'(obs_pt), 64'h900);
        chk("flush_call_cnt", 64'(obs_ck.count), 64'd4);
        flush(saved, 0, 1, 32'h0);
        dec(0, 0, 32'h0);
        chk("flush_ret_top", 64'(obs_pt), 64'h604);

        // advance low holds everything
        repeat (3) cyc(0, 0, 1, 0, 32'h111, 1, ck0, 1, 0, 32'h222);
        dec(0, 0, 32'h0);
        chk("hold_cnt", 64'(obs_ck.count), 64'd2);
        chk("hold_top", 64'(obs_pt), 64'h604);

        // reset mid-sequence
        dec(1, 0, 32'h333);
        cyc(1, 1, 1, 0, 32'h444, 0, ck0, 0, 0, 32'h0);
        dec(0, 0, 32'h0);
        chk("midrst_cnt", 64'(obs_ck.count), 64'd0);

        // random traffic against the model
        saved = last_ck;
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                flush(saved, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            end else if (sel == 1) begin
                cyc(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                    $urandom_range(0, 1) == 1, saved, 1, 0, $urandom);
            end else begin
                dec($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
                if ($urandom_range(0, 3) == 0) saved = last_ck;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
